mult_booth: RTL and testbench
=============================

MULT_BOOTH -- requirements
Module: mult_booth

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand width in bits; only WIDTH=32 is required to be supported.
REQ-002 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-003 SHALL have port reset, input, 1, reset is asynchronous and active-low.
REQ-004 SHALL have port start, input, 1, request to begin a multiply; sampled on rising edge.
REQ-005 SHALL have port a, input, WIDTH, multiplicand, two's complement.
REQ-006 SHALL have port b, input, WIDTH, multiplier, two's complement.
REQ-007 SHALL have port busy, output, 1, high while an operation is iterating.
REQ-008 SHALL have port done, output, 1, single-cycle completion pulse.
REQ-009 SHALL have port hi, output, WIDTH, upper half of the signed 2*WIDTH product.
REQ-010 SHALL have port lo, output, WIDTH, lower half of the signed 2*WIDTH product.

Function
REQ-011 SHALL implement radix-2 Booth signed multiplication, one iteration per clock, producing the exact 2*WIDTH-bit two's-complement product {hi,lo}.
REQ-012 SHALL use a three-state FSM: IDLE, RUN, DONE.
REQ-013 In IDLE with start=1 at edge E0, SHALL latch a and b, clear the accumulator and the iteration counter, and enter RUN.
REQ-014 SHALL perform iteration n on edge En (n=1..WIDTH), using the Booth pair {Q[0],Q[-1]}: 01 adds M, 10 subtracts M, 00/11 does nothing, followed by an arithmetic right shift of {ACC,Q,Q[-1]}.
REQ-015 ACC add/subtract SHALL be WIDTH+1 bits wide so that M = -2^(WIDTH-1) does not overflow.
REQ-016 On edge E_WIDTH, SHALL register the final product into hi/lo and enter DONE.
REQ-017 In DONE, SHALL assert done=1 for exactly one cycle, then return to IDLE on the next edge.
REQ-018 busy SHALL be 1 exactly while state is RUN.
REQ-019 Total latency SHALL be: done high in the cycle following edge E_WIDTH (WIDTH+1 edges after start is sampled); back-to-back throughput is one operation per WIDTH+2 cycles.
REQ-020 start SHALL be ignored in RUN and DONE; operand changes after E0 SHALL NOT affect the result.
REQ-021 hi/lo SHALL hold the last completed result until the next completion or reset, and SHALL NOT show intermediate values.
REQ-022 The iteration counter SHALL be ceil(log2(WIDTH+1)) bits and SHALL NOT wrap within an operation.

Reset
REQ-023 reset=0 SHALL asynchronously force state IDLE and busy=0, done=0, hi=0, lo=0, and clear all internal registers.
REQ-024 reset asserted mid-RUN SHALL abort the operation; after release, no done pulse for the aborted operation SHALL occur.
REQ-025 The first start SHALL be accepted on the first rising edge at which reset=1.

Configuration
REQ-026 Macro MULT_BOOTH_EARLY_ZERO_EN: when defined, start in IDLE with a==0 or b==0 SHALL go directly to DONE at E0 with hi=lo=0, skipping RUN (done high in the cycle after E0, busy stays 0).
REQ-027 Without MULT_BOOTH_EARLY_ZERO_EN, zero operands SHALL take the full WIDTH-iteration path with identical timing to any other operand.

Verification
REQ-028 a=3, b=5, start pulse -> busy for 32 cycles, done pulse in the 33rd cycle after start, hi=0x00000000, lo=0x0000000F.
REQ-029 a=0xFFFFFFFF (-1), b=1 -> hi=0xFFFFFFFF, lo=0xFFFFFFFF; a=0x80000000, b=0x80000000 -> hi=0x40000000, lo=0x00000000.
REQ-030 Start at cycle 0 with a=7, b=6; pulse start again with a=2, b=2 at cycle 10 -> single done, hi=0, lo=0x2A; second start ignored.
REQ-031 Start with a=0x1234, b=0x10; assert reset at cycle 15 -> outputs 0 immediately; release; no done pulse within 40 cycles.
REQ-032 a=0, b=0xDEADBEEF with MULT_BOOTH_EARLY_ZERO_EN -> done in the cycle after start, hi=lo=0, busy never 1; without the macro -> done after 33 cycles, hi=lo=0.
REQ-033 Random signed a,b, 1000 back-to-back operations -> {hi,lo} equals the 64-bit signed reference product every time.

Source files
------------

// File: rtl/mult_booth.sv
// mult_booth -- sequential radix-2 Booth signed multiplier.
//
// One Booth iteration per clock. A start in IDLE latches the operands and
// runs WIDTH iterations; the 2*WIDTH-bit signed product is registered into
// {hi,lo} on the last iteration, and done pulses for one cycle afterwards.
//
// Optional feature macro: MULT_BOOTH_EARLY_ZERO_EN
//   When defined, a start with a zero operand skips the iteration phase and
//   completes immediately with a zero product. When undefined, zero operands
//   take the full iteration path with the same timing as any other operand.

module mult_booth #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    // Iteration counter is sized to hold 0..WIDTH so it can never wrap
    // inside one operation.
    localparam int CNT_W = $clog2(WIDTH + 1);

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    // FSM encoding.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] m_q,     m_d;      // latched multiplicand
    logic [WIDTH:0]   acc_q,   acc_d;    // accumulator, one guard bit
    logic [WIDTH-1:0] q_q,     q_d;      // multiplier / product low half
    logic             qm1_q,   qm1_d;    // Booth bit Q[-1]
    logic [CNT_W-1:0] cnt_q,   cnt_d;    // completed-iteration count
    logic [WIDTH-1:0] hi_q,    hi_d;     // last completed product, upper
    logic [WIDTH-1:0] lo_q,    lo_d;     // last completed product, lower

    // ------------------------------------------------------------------
    // Zero-operand shortcut qualifier
    // ------------------------------------------------------------------
    logic zero_op;

`ifdef MULT_BOOTH_EARLY_ZERO_EN
    assign zero_op = (a == '0) || (b == '0);
`else
    assign zero_op = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Booth step datapath
    // ------------------------------------------------------------------
    // The multiplicand is sign-extended into a WIDTH+1 bit add/subtract so
    // that negating the most negative operand cannot overflow.
    logic [WIDTH:0]   m_ext;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   acc_step;
    logic [WIDTH-1:0] q_step;
    logic             qm1_step;

    // One Booth iteration: conditional add/subtract, then arithmetic shift
    // of {ACC,Q,Q[-1]} right by one.
    always_comb begin
        m_ext = {m_q[WIDTH-1], m_q};
        unique case ({q_q[0], qm1_q})
            2'b01:   sum = acc_q + m_ext;
            2'b10:   sum = acc_q - m_ext;
            default: sum = acc_q;
        endcase
        acc_step = {sum[WIDTH], sum[WIDTH:1]};
        q_step   = {sum[0], q_q[WIDTH-1:1]};
        qm1_step = q_q[0];
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    // FSM sequencing plus the datapath register updates for each state.
    always_comb begin
        // NOTE: every register holds by default so no path through this
        // block leaves a signal unassigned, which would infer a latch.
        state_d = state_q;
        m_d     = m_q;
        acc_d   = acc_q;
        q_d     = q_q;
        qm1_d   = qm1_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (zero_op) begin
                        // Product is trivially zero; complete right away.
                        hi_d    = '0;
                        lo_d    = '0;
                        state_d = ST_DONE;
                    end else begin
                        m_d     = a;
                        q_d     = b;
                        acc_d   = '0;
                        qm1_d   = 1'b0;
                        cnt_d   = '0;
                        state_d = ST_RUN;
                    end
                end
            end

            ST_RUN: begin
                acc_d = acc_step;
                q_d   = q_step;
                qm1_d = qm1_step;
                cnt_d = cnt_q + CNT_ONE;
                if (cnt_q == LAST_ITER) begin
                    // The true product fits in 2*WIDTH bits, so the guard
                    // bit of the accumulator is only a sign copy here.
                    hi_d    = acc_step[WIDTH-1:0];
                    lo_d    = q_step;
                    state_d = ST_DONE;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    // State and datapath registers with asynchronous active-low clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: every register is cleared, including the operand and
            // accumulator state, so an aborted operation leaves no trace.
            state_q <= ST_IDLE;
            m_q     <= '0;
            acc_q   <= '0;
            q_q     <= '0;
            qm1_q   <= 1'b0;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values regardless of statement order.
            state_q <= state_d;
            m_q     <= m_d;
            acc_q   <= acc_d;
            q_q     <= q_d;
            qm1_q   <= qm1_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign busy = (state_q == ST_RUN);
    assign done = (state_q == ST_DONE);
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mult_booth.sv
// tb_mult_booth -- self-checking bench for mult_booth.
//
// A cycle-level behavioural model (signed 64-bit product plus a busy
// countdown) is compared against the DUT on every falling edge, and
// directed vectors pin the model with hand-computed literals. Build with
// MULT_BOOTH_EARLY_ZERO_EN defined to exercise the zero-operand shortcut.

module tb_mult_booth;

    localparam int W = 32;

    logic          clk   = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic [W-1:0]  a     = '0;
    logic [W-1:0]  b     = '0;
    logic          busy;
    logic          done;
    logic [W-1:0]  hi;
    logic [W-1:0]  lo;

    always #5 clk = ~clk;

    mult_booth #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    int n_vec  = 0;
    int n_miss = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: cycles of busy remaining, a done flag and the
    // last completed product as plain signed arithmetic.
    // ------------------------------------------------------------------
    int          m_left = 0;
    logic        m_done = 1'b0;
    logic [63:0] m_res  = '0;
    logic [63:0] m_pend = '0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_left = 0;
            m_done = 1'b0;
            m_res  = '0;
            m_pend = '0;
        end else if (m_left > 0) begin
            m_left = m_left - 1;
            if (m_left == 0) begin
                m_res  = m_pend;
                m_done = 1'b1;
            end
        end else if (m_done) begin
            m_done = 1'b0;
        end else if (start) begin
            m_pend = 64'(longint'($signed(a)) * longint'($signed(b)));
`ifdef MULT_BOOTH_EARLY_ZERO_EN
            if (a == '0 || b == '0) begin
                m_res  = '0;
                m_done = 1'b1;
            end else begin
                m_left = W;
            end
`else
            m_left = W;
`endif
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    logic chk_en = 1'b0;

    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc_busy", 64'(busy), 64'(m_left > 0));
            check("cyc_done", 64'(done), 64'(m_done));
            check("cyc_hi",   64'(hi),   64'(m_res[63:32]));
            check("cyc_lo",   64'(lo),   64'(m_res[31:0]));
        end
    end

    // Launch one operation from a falling edge and wait for its done pulse.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input string tag,
                          output int cyc, output int busy_cyc);
        a        = ta;
        b        = tb_v;
        start    = 1'b1;
        cyc      = 0;
        busy_cyc = 0;
        while (cyc < 100) begin
            @(negedge clk);
            start = 1'b0;
            cyc++;
            if (busy) busy_cyc++;
            if (done) break;
        end
        if (!done) check({tag, "_timeout"}, 64'(0), 64'(1));
    endtask

    function automatic logic [W-1:0] pick_operand();
        int unsigned r;
        r = $urandom_range(0, 11);
        case (r)
            0:       return 32'h8000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h7FFF_FFFF;
            3:       return 32'h0000_0001;
            default: return $urandom;
        endcase
    endfunction

    int cyc, bcyc, nd, guard;

    initial begin
        // Reset state.
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_hi",   64'(hi),   64'(0));
        check("rst_lo",   64'(lo),   64'(0));

        // First start on the very first edge with reset released: 3*5.
        reset = 1'b1;
        run_op(32'd3, 32'd5, "op3x5", cyc, bcyc);
        check("op3x5_latency", 64'(cyc),  64'(33));
        check("op3x5_busy",    64'(bcyc), 64'(32));
        check("op3x5_hi",      64'(hi),   64'h0);
        check("op3x5_lo",      64'(lo),   64'hF);

        @(negedge clk);
        run_op(32'hFFFF_FFFF, 32'd1, "opm1x1", cyc, bcyc);
        check("opm1x1_hi", 64'(hi), 64'hFFFF_FFFF);
        check("opm1x1_lo", 64'(lo), 64'hFFFF_FFFF);

        @(negedge clk);
        run_op(32'h8000_0000, 32'h8000_0000, "opminsq", cyc, bcyc);
        check("opminsq_hi", 64'(hi), 64'h4000_0000);
        check("opminsq_lo", 64'(lo), 64'h0);

        @(negedge clk);
        run_op(32'h7FFF_FFFF, 32'h8000_0000, "opmaxmin", cyc, bcyc);
        check("opmaxmin_hi", 64'(hi), 64'hC000_0000);
        check("opmaxmin_lo", 64'(lo), 64'h8000_0000);

        // Second start during RUN must be ignored: 7*6, then 2*2 at cycle 10.
        @(negedge clk);
        a = 32'd7; b = 32'd6; start = 1'b1;
        nd = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            start = (c == 10);
            if (c == 10) begin
                a = 32'd2;
                b = 32'd2;
            end
            if (done) nd++;
        end
        start = 1'b0;
        check("ignore_dones", 64'(nd), 64'(1));
        check("ignore_hi",    64'(hi), 64'h0);
        check("ignore_lo",    64'(lo), 64'h2A);

        // Reset mid-RUN aborts the operation with no later done pulse.
        @(negedge clk);
        a = 32'h1234; b = 32'h10; start = 1'b1;
        for (int c = 1; c <= 15; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        #2 reset = 1'b0;
        #1;
        check("abort_busy", 64'(busy), 64'(0));
        check("abort_done", 64'(done), 64'(0));
        check("abort_hi",   64'(hi),   64'(0));
        check("abort_lo",   64'(lo),   64'(0));
        @(negedge clk);
        reset = 1'b1;
        nd = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (done) nd++;
        end
        check("abort_dones", 64'(nd), 64'(0));
        check("abort_lo_hold", 64'(lo), 64'(0));

        // Non-zero result first so the zero-operand result is observable.
        run_op(32'hFFFF_FFFD, 32'd7, "opm3x7", cyc, bcyc);
        check("opm3x7_hi", 64'(hi), 64'hFFFF_FFFF);
        check("opm3x7_lo", 64'(lo), 64'hFFFF_FFEB);

        @(negedge clk);
        run_op(32'd0, 32'hDEAD_BEEF, "opzero", cyc, bcyc);
`ifdef MULT_BOOTH_EARLY_ZERO_EN
        check("opzero_latency", 64'(cyc),  64'(1));
        check("opzero_busy",    64'(bcyc), 64'(0));
`else
        check("opzero_latency", 64'(cyc),  64'(33));
        check("opzero_busy",    64'(bcyc), 64'(32));
`endif
        check("opzero_hi", 64'(hi), 64'h0);
        check("opzero_lo", 64'(lo), 64'h0);

        // 1000 back-to-back random operations, start held high; the model
        // decides which operand pairs are accepted.
        @(negedge clk);
        start = 1'b1;
        nd    = 0;
        guard = 0;
        while (nd < 1000 && guard < 40000) begin
            a = pick_operand();
            b = pick_operand();
            @(negedge clk);
            guard++;
            if (done) nd++;
        end
        start = 1'b0;
        check("rand_ops", 64'(nd), 64'(1000));
        repeat (40) @(negedge clk);

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
